// File: rtl/data_sram_like_slave.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_like_slave
// Description : Data-side SRAM-like bus responder: word RAM with configurable
//               address-accept wait and fixed in-order response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_like_slave #(
    parameter int AW        = 10,
    parameter int QDEPTH    = 4,
    parameter int ADDR_WAIT = 0,
    parameter int DATA_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int c_PW  = $clog2(QDEPTH);
    localparam int c_CW  = $clog2(QDEPTH) + 1;
    localparam int c_AGW = $clog2(DATA_LAT + 1);
    localparam int c_WCW = (ADDR_WAIT > 0) ? $clog2(ADDR_WAIT + 1) : 1;

    logic [31:0]      r_mem    [0:(2**AW)-1];
    logic             r_q_wr   [QDEPTH];
    logic [31:0]      r_q_data [QDEPTH];
    logic [c_AGW-1:0] r_q_age  [QDEPTH];

    logic [c_PW-1:0]  r_head;
    logic [c_PW-1:0]  r_tail;
    logic [c_CW-1:0]  r_count;
    logic [c_WCW-1:0] r_wcnt;

    logic [AW-1:0]    w_idx;
    logic             w_wait_done;
    logic             w_push;
    logic             w_pop;
    logic             w_unused;

    assign w_idx    = addr[AW+1:2];
    assign w_unused = ^{size, addr[31:AW+2], addr[1:0], r_wcnt};

    generate
        if (ADDR_WAIT == 0) begin : g_wait_none
            assign w_wait_done = 1'b1;
        end else begin : g_wait_cnt
            assign w_wait_done = (r_wcnt >= c_WCW'(ADDR_WAIT));
        end
    endgenerate

    // No bypass when full: accept depends only on the registered count.
    assign addr_ok = req & ~reset & (r_count < c_CW'(QDEPTH)) & w_wait_done;
    assign data_ok = ~reset & (r_count != '0) & (r_q_age[r_head] == c_AGW'(DATA_LAT));
    assign rdata   = (data_ok & ~r_q_wr[r_head]) ? r_q_data[r_head] : 32'd0;

    assign w_push  = req & addr_ok;
    assign w_pop   = data_ok;

    always_ff @(posedge clk) begin
        if (w_push && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // A pushed entry already counts its accept edge, so DATA_LAT=1 answers
    // in the cycle right after the accept.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (r_q_age[i] != c_AGW'(DATA_LAT)) begin
                r_q_age[i] <= r_q_age[i] + c_AGW'(1);
            end
        end
        if (w_push) begin
            r_q_wr[r_tail]   <= wr;
            r_q_data[r_tail] <= wr ? 32'd0 : r_mem[w_idx];
            r_q_age[r_tail]  <= c_AGW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_wcnt  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (!req || w_push) begin
                r_wcnt <= '0;
            end else if (r_wcnt != c_WCW'(ADDR_WAIT)) begin
                r_wcnt <= r_wcnt + c_WCW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_like_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_like_slave
// Description : Bench for data_sram_like_slave over three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_like_slave;

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
        int          due;
    } resp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst, req, wr, addr_ok, data_ok;
    logic [1:0]  size  [3];
    logic [31:0] addr  [3];
    logic [3:0]  wstrb [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];

    resp_t       mq [3][$];
    logic [31:0] mem_m [3][1024];
    int          held [3];
    int          lat_k [3];
    int          wait_k [3];
    int          dok_cnt [3];
    logic [31:0] last_rd [3];
    logic [2:0]  hs;
    int          cyc;
    int          checks;
    int          failures;

    always #5 clk = ~clk;

    data_sram_like_slave #(.AW(10), .QDEPTH(4), .ADDR_WAIT(0), .DATA_LAT(1)) u_dut0 (
        .clk(clk), .reset(rst[0]), .req(req[0]), .wr(wr[0]), .size(size[0]),
        .addr(addr[0]), .wstrb(wstrb[0]), .wdata(wdata[0]),
        .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));

    data_sram_like_slave #(.AW(10), .QDEPTH(4), .ADDR_WAIT(0), .DATA_LAT(8)) u_dut1 (
        .clk(clk), .reset(rst[1]), .req(req[1]), .wr(wr[1]), .size(size[1]),
        .addr(addr[1]), .wstrb(wstrb[1]), .wdata(wdata[1]),
        .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));

    data_sram_like_slave #(.AW(10), .QDEPTH(4), .ADDR_WAIT(3), .DATA_LAT(2)) u_dut2 (
        .clk(clk), .reset(rst[2]), .req(req[2]), .wr(wr[2]), .size(size[2]),
        .addr(addr[2]), .wstrb(wstrb[2]), .wdata(wdata[2]),
        .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]));

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: compare every instance against the model, advance the model.
    task automatic cycle();
        logic        exp_aok;
        logic        exp_dok;
        logic [31:0] exp_rd;
        int          idx;
        resp_t       e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            exp_aok = req[k] && !rst[k] && (mq[k].size() < 4) && (held[k] >= wait_k[k]);
            exp_dok = 1'b0;
            exp_rd  = 32'd0;
            if (!rst[k] && mq[k].size() > 0) begin
                exp_dok = (mq[k][0].due <= cyc);
                if (exp_dok && !mq[k][0].is_wr) exp_rd = mq[k][0].data;
            end
            check32($sformatf("addr_ok[%0d]@%0d", k, cyc), {31'd0, addr_ok[k]}, {31'd0, exp_aok});
            check32($sformatf("data_ok[%0d]@%0d", k, cyc), {31'd0, data_ok[k]}, {31'd0, exp_dok});
            check32($sformatf("rdata[%0d]@%0d", k, cyc), rdata[k], exp_rd);
            hs[k] = req[k] & addr_ok[k];
            if (data_ok[k]) begin
                dok_cnt[k]++;
                last_rd[k] = rdata[k];
            end
            if (rst[k]) begin
                mq[k].delete();
                held[k] = 0;
            end else begin
                if (exp_dok) void'(mq[k].pop_front());
                if (exp_aok) begin
                    idx     = int'(addr[k][11:2]);
                    e.is_wr = wr[k];
                    e.due   = cyc + lat_k[k];
                    e.data  = wr[k] ? 32'd0 : mem_m[k][idx];
                    if (wr[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (wstrb[k][b]) mem_m[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
                    end
                    mq[k].push_back(e);
                end
                held[k] = (!req[k] || exp_aok) ? 0 : held[k] + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input int k, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        int n;
        req[k] = 1'b1; wr[k] = w; addr[k] = a; wstrb[k] = s; wdata[k] = d; size[k] = 2'd2;
        n = 0;
        hs[k] = 1'b0;
        while (!hs[k] && n < 60) begin
            cycle();
            n++;
        end
        check32($sformatf("accept[%0d]", k), {31'd0, hs[k]}, 32'd1);
        req[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (mq[k].size() > 0 && n < 60) begin
            cycle();
            n++;
        end
        cycle();
        check32($sformatf("drain[%0d]", k), mq[k].size(), 32'd0);
    endtask

    initial begin
        int          d0;
        int          c0;
        int          k;
        logic [31:0] a;
        checks = 0; failures = 0; cyc = 0;
        lat_k  = '{1, 8, 2};
        wait_k = '{0, 0, 3};
        for (int i = 0; i < 3; i++) begin
            held[i] = 0; dok_cnt[i] = 0; last_rd[i] = 32'd0;
            size[i] = 2'd0; addr[i] = 32'd0; wstrb[i] = 4'd0; wdata[i] = 32'd0;
        end
        rst = 3'b111; req = 3'b000; wr = 3'b000; hs = 3'b000;
        idle(2);
        rst = 3'b000;
        idle(1);

        // Full word write, then read it back.
        issue(0, 1'b1, 32'h10, 4'hF, 32'h12345678);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0);
        drain(0);
        check32("t1_read", last_rd[0], 32'h12345678);

        // Single byte lane merge.
        issue(0, 1'b1, 32'h10, 4'b0100, 32'h00AB0000);
        drain(0);
        check32("t2_wr_rdata", last_rd[0], 32'h0);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0);
        drain(0);
        check32("t2_read", last_rd[0], 32'h12AB5678);

        // Write then read the same word on consecutive accepts.
        issue(0, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
        issue(0, 1'b0, 32'h20, 4'h0, 32'h0);
        drain(0);
        check32("t6_read", last_rd[0], 32'hCAFEF00D);

        // Long latency: fifth read stalls on a full queue.
        for (int i = 0; i < 5; i++) issue(1, 1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hA5000000 + 32'(i));
        drain(1);
        d0 = dok_cnt[1];
        for (int i = 0; i < 5; i++) issue(1, 1'b0, 32'h100 + 32'(4*i), 4'h0, 32'h0);
        drain(1);
        check32("t3_resp_count", dok_cnt[1] - d0, 32'd5);
        check32("t3_last", last_rd[1], 32'hA5000004);

        // Reset with two reads outstanding.
        issue(1, 1'b0, 32'h100, 4'h0, 32'h0);
        issue(1, 1'b0, 32'h104, 4'h0, 32'h0);
        rst[1] = 1'b1;
        idle(1);
        rst[1] = 1'b0;
        d0 = dok_cnt[1];
        idle(12);
        check32("t5_no_resp", dok_cnt[1] - d0, 32'd0);
        issue(1, 1'b0, 32'h104, 4'h0, 32'h0);
        drain(1);
        check32("t5_reread", last_rd[1], 32'hA5000001);

        // Address wait: accept only after three held cycles; early drop never accepts.
        c0 = cyc;
        issue(2, 1'b1, 32'h40, 4'hF, 32'h55AA33CC);
        check32("t4_wait", cyc - 1 - c0, 32'd3);
        drain(2);
        d0 = dok_cnt[2];
        req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h40;
        idle(2);
        req[2] = 1'b0;
        idle(10);
        check32("t4_drop", dok_cnt[2] - d0, 32'd0);
        issue(2, 1'b0, 32'h40, 4'h0, 32'h0);
        drain(2);
        check32("t4_read", last_rd[2], 32'h55AA33CC);

        // Randomized traffic over a preloaded window, with aliased upper address bits.
        for (int i = 0; i < 16; i++) begin
            issue(0, 1'b1, 32'(4*i), 4'hF, $urandom());
            issue(2, 1'b1, 32'(4*i), 4'hF, $urandom());
        end
        drain(0);
        drain(2);
        for (int i = 0; i < 120; i++) begin
            k = ($urandom_range(0, 2) == 0) ? 2 : 0;
            a = $urandom();
            a[11:6] = 6'd0;
            a[1:0]  = 2'd0;
            issue(k, 1'($urandom_range(0, 1)), a, 4'($urandom()), $urandom());
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain(0);
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
